// File: rtl/otbn_keccak_plane_seq.sv
// Keccak plane sequencer. It latches a 1600-bit state and walks the shared
// combinational plane unit row by row. It produces either the five theta
// D-lanes or a full chi step, and returns the result over a valid/ready
// handshake.
module otbn_keccak_plane_seq (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [1599:0] state_i,
  output logic          busy_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [1599:0] result_o,
  output logic          plane_op_o,
  output logic          plane_en_o,
  output logic [255:0]  plane_a_o,
  output logic [255:0]  plane_b_o,
  input  logic [255:0]  plane_rs0_i,
  input  logic [255:0]  plane_rs1_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARITY,
    S_THETA,
    S_CHI,
    S_DONE
  } state_e;

  state_e          r_fsm;
  state_e          w_fsm_nxt;
  logic [1599:0]   r_buf;
  logic [319:0]    r_c;
  logic [2:0]      r_row;
  logic            r_mode;
  logic [1599:0]   r_result;

  logic [319:0]    w_row;
  logic [319:0]    w_plane_res;
  logic            w_unused_rs1;

  // Only lane 4 of the second result bus carries data.
  assign w_plane_res  = {plane_rs1_i[63:0], plane_rs0_i};
  assign w_unused_rs1 = ^plane_rs1_i[255:64];

  // Select the current row (five lanes) of the latched state.
  always_comb begin
    w_row = '0;
    case (r_row)
      3'd0:    w_row = r_buf[319:0];
      3'd1:    w_row = r_buf[639:320];
      3'd2:    w_row = r_buf[959:640];
      3'd3:    w_row = r_buf[1279:960];
      3'd4:    w_row = r_buf[1599:1280];
      default: w_row = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:   if (start_i) w_fsm_nxt = r_mode_sel(mode_i);
      S_PARITY: if (r_row == 3'd4) w_fsm_nxt = S_THETA;
      S_THETA:  w_fsm_nxt = S_DONE;
      S_CHI:    if (r_row == 3'd4) w_fsm_nxt = S_DONE;
      S_DONE:   if (ready_i) w_fsm_nxt = S_IDLE;
      default:  w_fsm_nxt = S_IDLE;
    endcase
  end

  function automatic state_e r_mode_sel(input logic m);
    return m ? S_CHI : S_PARITY;
  endfunction

  // Plane bus drive; blanked to zero outside THETA and CHI.
  always_comb begin
    plane_en_o = 1'b0;
    plane_op_o = 1'b0;
    plane_a_o  = '0;
    plane_b_o  = '0;
    case (r_fsm)
      S_THETA: begin
        plane_en_o = 1'b1;
        plane_a_o  = r_c[255:0];
        plane_b_o  = {192'd0, r_c[319:256]};
      end
      S_CHI: begin
        plane_en_o = 1'b1;
        plane_op_o = 1'b1;
        plane_a_o  = w_row[255:0];
        plane_b_o  = {192'd0, w_row[319:256]};
      end
      default: ;
    endcase
  end

  // State register, datapath registers and result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm    <= S_IDLE;
      r_buf    <= '0;
      r_c      <= '0;
      r_row    <= '0;
      r_mode   <= 1'b0;
      r_result <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      case (r_fsm)
        S_IDLE: begin
          if (start_i) begin
            r_buf  <= state_i;
            r_mode <= mode_i;
            r_c    <= '0;
            r_row  <= '0;
          end
        end
        S_PARITY: begin
          r_c   <= r_c ^ w_row;
          r_row <= (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
        end
        S_THETA: begin
          r_result <= {1280'd0, w_plane_res};
        end
        S_CHI: begin
          for (int unsigned y = 0; y < 5; y++) begin
            if (r_row == y[2:0]) r_result[320*y +: 320] <= w_plane_res;
          end
          r_row <= (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (r_fsm != S_IDLE);
  assign valid_o  = (r_fsm == S_DONE);
  assign result_o = r_result;

endmodule

// File: tb/tb_otbn_keccak_plane_seq.sv
// Testbench for otbn_keccak_plane_seq: behavioural plane unit, full-state
// Keccak theta/chi reference, randomized runs plus directed corner cases.
module tb_otbn_keccak_plane_seq;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          mode_i;
  logic [1599:0] state_i;
  logic          busy_o;
  logic          valid_o;
  logic          ready_i;
  logic [1599:0] result_o;
  logic          plane_op_o;
  logic          plane_en_o;
  logic [255:0]  plane_a_o;
  logic [255:0]  plane_b_o;
  logic [255:0]  plane_rs0_i;
  logic [255:0]  plane_rs1_i;

  int n_checks = 0;
  int n_errors = 0;

  otbn_keccak_plane_seq u_dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .state_i    (state_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .plane_op_o (plane_op_o),
    .plane_en_o (plane_en_o),
    .plane_a_o  (plane_a_o),
    .plane_b_o  (plane_b_o),
    .plane_rs0_i(plane_rs0_i),
    .plane_rs1_i(plane_rs1_i)
  );

  always #5 clk = ~clk;

  // Plane unit model: theta D-lanes from a parity plane, or one chi row.
  // Unused upper bits of rs1 carry junk that the sequencer must ignore.
  logic [63:0] pl_in  [5];
  logic [63:0] pl_out [5];
  always_comb begin
    for (int x = 0; x < 4; x++) pl_in[x] = plane_a_o[64*x +: 64];
    pl_in[4] = plane_b_o[63:0];
    for (int x = 0; x < 5; x++) pl_out[x] = '0;
    if (plane_en_o) begin
      for (int x = 0; x < 5; x++) begin
        if (plane_op_o)
          pl_out[x] = pl_in[x] ^ (~pl_in[(x+1)%5] & pl_in[(x+2)%5]);
        else
          pl_out[x] = pl_in[(x+4)%5] ^ {pl_in[(x+1)%5][62:0], pl_in[(x+1)%5][63]};
      end
    end
    plane_rs0_i = {pl_out[3], pl_out[2], pl_out[1], pl_out[0]};
    plane_rs1_i = {192'hA5A5_5A5A_C3C3_3C3C_F00F_0FF0_1234_5678_9ABC_DEF0_0F1E_2D3C, pl_out[4]};
  end

  // Full-state theta D-lane reference: column parities, then D[x].
  function automatic logic [1599:0] ref_theta(input logic [1599:0] s);
    logic [63:0]   c [5];
    logic [1599:0] r;
    r = '0;
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] = c[x] ^ s[64*(x+5*y) +: 64];
    end
    for (int x = 0; x < 5; x++)
      r[64*x +: 64] = c[(x+4)%5] ^ {c[(x+1)%5][62:0], c[(x+1)%5][63]};
    return r;
  endfunction

  // Full-state chi reference.
  function automatic logic [1599:0] ref_chi(input logic [1599:0] s);
    logic [1599:0] r;
    logic [63:0]   a0, a1, a2;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        a0 = s[64*(x+5*y) +: 64];
        a1 = s[64*(((x+1)%5)+5*y) +: 64];
        a2 = s[64*(((x+2)%5)+5*y) +: 64];
        r[64*(x+5*y) +: 64] = a0 ^ (~a1 & a2);
      end
    return r;
  endfunction

  // Compare; on mismatch report the first differing 64-bit lane.
  task automatic check(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      for (int l = 0; l < 25; l++) begin
        if (got[64*l +: 64] !== exp[64*l +: 64]) begin
          $display("FAIL %s lane%0d got=%h exp=%h", tag, l, got[64*l +: 64], exp[64*l +: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom();
    return s;
  endfunction

  // One complete operation with cycle-accurate checks; inputs change on negedge.
  task automatic run_op(input string tag, input logic m, input logic [1599:0] st,
                        input logic [1599:0] exp, input int hold, input bit early_ready);
    int lat;
    lat = m ? 6 : 7;
    @(negedge clk);
    state_i = st; mode_i = m; start_i = 1'b1; ready_i = early_ready;
    @(negedge clk);
    start_i = 1'b0; state_i = rand_state(); mode_i = ~m;
    for (int k = 1; k <= lat; k++) begin
      logic en_e, op_e;
      en_e = m ? (k <= 5) : (k == 6);
      op_e = m && (k <= 5);
      check({tag, ".busy"},  {1599'd0, busy_o},     {1599'd0, 1'b1});
      check({tag, ".valid"}, {1599'd0, valid_o},    {1599'd0, k == lat});
      check({tag, ".en"},    {1599'd0, plane_en_o}, {1599'd0, en_e});
      check({tag, ".op"},    {1599'd0, plane_op_o}, {1599'd0, op_e});
      if (!en_e) check({tag, ".blank"}, {1088'd0, plane_a_o, plane_b_o}, '0);
      else       check({tag, ".bhi"},   {1408'd0, plane_b_o[255:64]}, '0);
      if (k < lat) @(negedge clk);
    end
    check({tag, ".result"}, result_o, exp);
    if (!early_ready) begin
      for (int h = 0; h < hold; h++) begin
        start_i = h[0];
        @(negedge clk);
        check({tag, ".holdv"}, {1599'd0, valid_o}, {1599'd0, 1'b1});
        check({tag, ".holdr"}, result_o, exp);
      end
      ready_i = 1'b1;
      start_i = 1'b1;
    end
    @(negedge clk);
    ready_i = 1'b0;
    start_i = 1'b0;
    check({tag, ".postv"}, {1599'd0, valid_o}, '0);
    check({tag, ".postb"}, {1599'd0, busy_o},  '0);
    check({tag, ".postr"}, result_o, exp);
  endtask

  initial begin
    logic [1599:0] s, e;
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; ready_i = 1'b0; state_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst.busy",  {1599'd0, busy_o},  '0);
    check("rst.valid", {1599'd0, valid_o}, '0);
    check("rst.res",   result_o, '0);
    check("rst.plane", {1086'd0, plane_en_o, plane_op_o, plane_a_o, plane_b_o}, '0);
    rst_i = 1'b0;

    // Zero state theta.
    run_op("theta0", 1'b0, '0, '0, 2, 1'b0);

    // Single bit in lane (0,0): D1 = 1, D4 = 2.
    s = '0; s[0] = 1'b1;
    e = '0; e[64 +: 64] = 64'h1; e[256 +: 64] = 64'h2;
    run_op("theta1", 1'b0, s, e, 1, 1'b0);

    // All ones chi.
    run_op("chi1s", 1'b1, '1, '1, 0, 1'b0);

    // Lane (2,0) all ones -> lanes (0,0),(2,0) all ones.
    s = '0; s[128 +: 64] = '1;
    e = '0; e[0 +: 64] = '1; e[128 +: 64] = '1;
    run_op("chilane", 1'b1, s, e, 1, 1'b0);

    // Backpressure with start pulses, then a restart.
    s = rand_state();
    run_op("bp", 1'b1, s, ref_chi(s), 10, 1'b0);
    s = rand_state();
    run_op("restart", 1'b0, s, ref_theta(s), 0, 1'b0);

    // Ready asserted before valid.
    s = rand_state();
    run_op("early", 1'b1, s, ref_chi(s), 0, 1'b1);

    // Reset in the CHI row-2 cycle.
    s = rand_state();
    @(negedge clk);
    state_i = s; mode_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.row2", {1344'd0, plane_a_o}, {1344'd0, s[640 +: 256]});
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort.busy",  {1599'd0, busy_o},  '0);
    check("abort.valid", {1599'd0, valid_o}, '0);
    check("abort.res",   result_o, '0);
    check("abort.plane", {1086'd0, plane_en_o, plane_op_o, plane_a_o, plane_b_o}, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort.novalid", {1598'd0, valid_o, busy_o}, '0);
    end
    s = rand_state();
    run_op("aftrst", 1'b0, s, ref_theta(s), 1, 1'b0);

    // Randomized runs.
    for (int i = 0; i < 12; i++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      s = rand_state();
      e = m ? ref_chi(s) : ref_theta(s);
      run_op(m ? "rchi" : "rtheta", m, s, e, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
